// File: rtl/turn_controller_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : turn_controller_pkg                                       |
// | Purpose  : Shared state codes and defaults for the turn controller   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package turn_controller_pkg;

  // Default width of the completed half-move counter.
  localparam int MOVE_W_DEFAULT = 10;

  // FSM state codes; the numeric values are visible on the STATE port.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN_P1  = 3'd1,
    RUN_P2  = 3'd2,
    PAUSED  = 3'd3,
    TIMEOUT = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/turn_controller_edge_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : edge_detect                                               |
// | Purpose  : Rising-edge pulse from a pre-synchronized button level    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module edge_detect (
  input  logic CLK,
  input  logic CLR,
  input  logic LEVEL,
  output logic PULSE
);

  logic level_q, level_d;
  logic arm_q, arm_d;

  // Track the previous level; arm only once the button has been seen low,
  // so a press held through reset release never produces a pulse.
  always_comb begin
    level_d = LEVEL;
    arm_d   = arm_q | ~LEVEL;
  end

  // Edge registers: cleared on reset, arm reflects the level at reset time.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      level_q <= 1'b0;
      arm_q   <= ~LEVEL;
    end else begin
      level_q <= level_d;
      arm_q   <= arm_d;
    end
  end

  assign PULSE = LEVEL & ~level_q & arm_q;

endmodule
`default_nettype wire

// File: rtl/turn_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : turn_controller                                           |
// | Purpose  : Two-player chess-clock turn FSM with pause and timeout    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module turn_controller
  import turn_controller_pkg::*;
#(
  parameter int MOVE_W = MOVE_W_DEFAULT
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              CE,
  input  logic              START,
  input  logic              PAUSE,
  input  logic              BTN_P1,
  input  logic              BTN_P2,
  input  logic              OVERFLOW1,
  input  logic              OVERFLOW2,
  output logic              EN_P1,
  output logic              EN_P2,
  output logic              TMR_CLR,
  output logic              FLAG_P1,
  output logic              FLAG_P2,
  output logic [MOVE_W-1:0] MOVE_CNT,
  output logic [2:0]        STATE
);

  localparam logic [MOVE_W-1:0] CNT_MAX = '1;

  logic start_edge, pause_edge, p1_edge, p2_edge;

  state_e            state_q, state_d;
  state_e            resume_q, resume_d;
  logic [MOVE_W-1:0] move_cnt_q, move_cnt_d;
  logic              flag_p1_q, flag_p1_d;
  logic              flag_p2_q, flag_p2_d;
  logic              en_p1_q, en_p1_d;
  logic              en_p2_q, en_p2_d;
  logic              tmr_clr_q, tmr_clr_d;

  edge_detect u_ed_start (.CLK(CLK), .CLR(CLR), .LEVEL(START),  .PULSE(start_edge));
  edge_detect u_ed_pause (.CLK(CLK), .CLR(CLR), .LEVEL(PAUSE),  .PULSE(pause_edge));
  edge_detect u_ed_p1    (.CLK(CLK), .CLR(CLR), .LEVEL(BTN_P1), .PULSE(p1_edge));
  edge_detect u_ed_p2    (.CLK(CLK), .CLR(CLR), .LEVEL(BTN_P2), .PULSE(p2_edge));

  // Next-state and registered-output logic; CE low freezes everything and
  // drops the enables and clear pulse.
  always_comb begin
    state_d    = state_q;
    resume_d   = resume_q;
    move_cnt_d = move_cnt_q;
    flag_p1_d  = flag_p1_q;
    flag_p2_d  = flag_p2_q;
    tmr_clr_d  = 1'b0;
    en_p1_d    = 1'b0;
    en_p2_d    = 1'b0;

    if (CE) begin
      unique case (state_q)
        IDLE: begin
          if (start_edge) state_d = RUN_P1;
        end
        RUN_P1: begin
          // Own timer expiry beats the move button, which beats pause.
          if (OVERFLOW1) begin
            state_d   = TIMEOUT;
            flag_p1_d = 1'b1;
          end else if (p1_edge) begin
            state_d = RUN_P2;
            if (move_cnt_q != CNT_MAX) move_cnt_d = move_cnt_q + 1'b1;
          end else if (pause_edge) begin
            state_d  = PAUSED;
            resume_d = RUN_P1;
          end
        end
        RUN_P2: begin
          if (OVERFLOW2) begin
            state_d   = TIMEOUT;
            flag_p2_d = 1'b1;
          end else if (p2_edge) begin
            state_d = RUN_P1;
            if (move_cnt_q != CNT_MAX) move_cnt_d = move_cnt_q + 1'b1;
          end else if (pause_edge) begin
            state_d  = PAUSED;
            resume_d = RUN_P2;
          end
        end
        PAUSED: begin
          if (pause_edge) state_d = resume_q;
        end
        TIMEOUT: begin
          if (start_edge) begin
            state_d    = IDLE;
            tmr_clr_d  = 1'b1;
            flag_p1_d  = 1'b0;
            flag_p2_d  = 1'b0;
            move_cnt_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase

      // Enables follow the state being entered, so they are mutually exclusive.
      en_p1_d = (state_d == RUN_P1);
      en_p2_d = (state_d == RUN_P2);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q    <= IDLE;
      resume_q   <= RUN_P1;
      move_cnt_q <= '0;
      flag_p1_q  <= 1'b0;
      flag_p2_q  <= 1'b0;
      en_p1_q    <= 1'b0;
      en_p2_q    <= 1'b0;
      tmr_clr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      resume_q   <= resume_d;
      move_cnt_q <= move_cnt_d;
      flag_p1_q  <= flag_p1_d;
      flag_p2_q  <= flag_p2_d;
      en_p1_q    <= en_p1_d;
      en_p2_q    <= en_p2_d;
      tmr_clr_q  <= tmr_clr_d;
    end
  end

  assign EN_P1    = en_p1_q;
  assign EN_P2    = en_p2_q;
  assign TMR_CLR  = tmr_clr_q;
  assign FLAG_P1  = flag_p1_q;
  assign FLAG_P2  = flag_p2_q;
  assign MOVE_CNT = move_cnt_q;
  assign STATE    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_turn_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_turn_controller                                        |
// | Purpose  : Directed + random bench with a game-rule reference model  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_turn_controller;

  localparam int SMALL_W = 3;
  localparam int BIG_MAX = (1 << 10) - 1;
  localparam int SMALL_MAX = (1 << SMALL_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic CLR, CE, START, PAUSE, BTN_P1, BTN_P2, OVERFLOW1, OVERFLOW2;

  logic       en_p1, en_p2, tmr_clr, flag_p1, flag_p2;
  logic [9:0] move_cnt;
  logic [2:0] state;

  logic         s_en_p1, s_en_p2, s_tmr_clr, s_flag_p1, s_flag_p2;
  logic [SMALL_W-1:0] s_move_cnt;
  logic [2:0]   s_state;

  turn_controller dut (
    .CLK(clk), .CLR(CLR), .CE(CE), .START(START), .PAUSE(PAUSE),
    .BTN_P1(BTN_P1), .BTN_P2(BTN_P2), .OVERFLOW1(OVERFLOW1), .OVERFLOW2(OVERFLOW2),
    .EN_P1(en_p1), .EN_P2(en_p2), .TMR_CLR(tmr_clr), .FLAG_P1(flag_p1),
    .FLAG_P2(flag_p2), .MOVE_CNT(move_cnt), .STATE(state)
  );

  turn_controller #(.MOVE_W(SMALL_W)) dut_s (
    .CLK(clk), .CLR(CLR), .CE(CE), .START(START), .PAUSE(PAUSE),
    .BTN_P1(BTN_P1), .BTN_P2(BTN_P2), .OVERFLOW1(OVERFLOW1), .OVERFLOW2(OVERFLOW2),
    .EN_P1(s_en_p1), .EN_P2(s_en_p2), .TMR_CLR(s_tmr_clr), .FLAG_P1(s_flag_p1),
    .FLAG_P2(s_flag_p2), .MOVE_CNT(s_move_cnt), .STATE(s_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: game phase as a plain number, the side to resume,
  // an unbounded move tally clipped per counter width, and last-seen levels.
  int m_phase, m_resume, m_moves;
  bit m_f1, m_f2, m_en1, m_en2, m_tclr;
  bit last_start, last_pause, last_b1, last_b2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit ev_start, ev_pause, ev_b1, ev_b2;
    ev_start = START && !last_start;
    ev_pause = PAUSE && !last_pause;
    ev_b1    = BTN_P1 && !last_b1;
    ev_b2    = BTN_P2 && !last_b2;
    m_tclr = 0;
    if (CLR) begin
      m_phase = 0; m_resume = 1; m_moves = 0; m_f1 = 0; m_f2 = 0;
      m_en1 = 0; m_en2 = 0;
    end else if (!CE) begin
      m_en1 = 0; m_en2 = 0;
    end else begin
      if (m_phase == 0) begin
        if (ev_start) m_phase = 1;
      end else if (m_phase == 1 || m_phase == 2) begin
        bit ovf, mine;
        ovf  = (m_phase == 1) ? OVERFLOW1 : OVERFLOW2;
        mine = (m_phase == 1) ? ev_b1 : ev_b2;
        if (ovf) begin
          if (m_phase == 1) m_f1 = 1; else m_f2 = 1;
          m_phase = 4;
        end else if (mine) begin
          m_moves++;
          m_phase = 3 - m_phase;
        end else if (ev_pause) begin
          m_resume = m_phase;
          m_phase = 3;
        end
      end else if (m_phase == 3) begin
        if (ev_pause) m_phase = m_resume;
      end else if (m_phase == 4) begin
        if (ev_start) begin
          m_phase = 0; m_tclr = 1; m_f1 = 0; m_f2 = 0; m_moves = 0;
        end
      end
      m_en1 = (m_phase == 1);
      m_en2 = (m_phase == 2);
    end
    last_start = START; last_pause = PAUSE; last_b1 = BTN_P1; last_b2 = BTN_P2;
  endtask

  task automatic check_all();
    chk("state",      state,    m_phase);
    chk("en_p1",      en_p1,    m_en1);
    chk("en_p2",      en_p2,    m_en2);
    chk("tmr_clr",    tmr_clr,  m_tclr);
    chk("flag_p1",    flag_p1,  m_f1);
    chk("flag_p2",    flag_p2,  m_f2);
    chk("move_cnt",   move_cnt, (m_moves > BIG_MAX) ? BIG_MAX : m_moves);
    chk("no_overlap", en_p1 & en_p2, 0);
    chk("s_state",    s_state,  m_phase);
    chk("s_move_cnt", s_move_cnt, (m_moves > SMALL_MAX) ? SMALL_MAX : m_moves);
    chk("s_no_overlap", s_en_p1 & s_en_p2, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  // Press and release one button: 0=START 1=PAUSE 2=BTN_P1 3=BTN_P2.
  task automatic press(input int which, input int hold);
    case (which)
      0: START = 1; 1: PAUSE = 1; 2: BTN_P1 = 1; default: BTN_P2 = 1;
    endcase
    repeat (hold) tick();
    START = 0; PAUSE = 0; BTN_P1 = 0; BTN_P2 = 0;
    tick();
  endtask

  initial begin
    m_phase = 0; m_resume = 1; m_moves = 0; m_f1 = 0; m_f2 = 0;
    m_en1 = 0; m_en2 = 0; m_tclr = 0;
    last_start = 0; last_pause = 0; last_b1 = 0; last_b2 = 0;
    CLR = 1; CE = 1; START = 0; PAUSE = 0; BTN_P1 = 0; BTN_P2 = 0;
    OVERFLOW1 = 0; OVERFLOW2 = 0;
    tick(); tick();
    CLR = 0;
    tick();
    chk("reset_state", state, 3'd0);
    chk("reset_cnt", move_cnt, 10'd0);

    // Start a game.
    START = 1; tick();
    chk("start_state", state, 3'd1);
    chk("start_en1", en_p1, 1'b1);
    START = 0; tick();

    // Six alternating presses, the third one held 20 cycles.
    for (int i = 0; i < 6; i++) press((i % 2 == 0) ? 2 : 3, (i == 2) ? 20 : 1);
    chk("six_moves_cnt", move_cnt, 10'd6);
    chk("six_moves_state", state, 3'd1);

    // Pause during RUN_P2 with the player-2 button toggling.
    press(2, 1);
    press(1, 1);
    chk("paused_state", state, 3'd3);
    chk("paused_en", {en_p1, en_p2}, 2'b00);
    for (int i = 0; i < 10; i++) begin BTN_P2 = ~BTN_P2; tick(); end
    BTN_P2 = 0; tick();
    press(1, 1);
    chk("resume_state", state, 3'd2);
    chk("resume_cnt", move_cnt, 10'd7);

    // Two more moves: small counter saturates at 7.
    press(3, 1);
    press(2, 1);
    chk("sat_small", s_move_cnt, 3'd7);
    chk("sat_big", move_cnt, 10'd9);
    press(3, 1);

    // Idle-side overflow ignored, then own overflow beats move button.
    OVERFLOW2 = 1; tick(); OVERFLOW2 = 0;
    chk("idle_ovf_state", state, 3'd1);
    OVERFLOW1 = 1; BTN_P1 = 1; tick();
    chk("timeout_state", state, 3'd4);
    chk("timeout_flag1", flag_p1, 1'b1);
    chk("timeout_cnt", move_cnt, 10'd10);
    OVERFLOW1 = 0; BTN_P1 = 0; tick();
    START = 1; tick();
    chk("rematch_state", state, 3'd0);
    chk("rematch_tclr", tmr_clr, 1'b1);
    chk("rematch_flag", flag_p1, 1'b0);
    START = 0; tick();
    chk("tclr_one_cycle", tmr_clr, 1'b0);

    // CE low freezes a running game while a press comes and goes.
    press(0, 1);
    CE = 0; tick();
    chk("ce_off_en1", en_p1, 1'b0);
    BTN_P1 = 1; tick(); tick(); BTN_P1 = 0; tick();
    CE = 1; tick();
    chk("ce_on_state", state, 3'd1);
    chk("ce_on_en1", en_p1, 1'b1);
    chk("ce_on_cnt", move_cnt, 10'd0);

    // Reset mid RUN_P2, then a START held through reset release.
    press(2, 1);
    CLR = 1; START = 1; tick();
    chk("clr_outputs", {state, en_p1, en_p2, tmr_clr, flag_p1, flag_p2, move_cnt}, 18'd0);
    CLR = 0; tick(); tick();
    chk("held_start_no_edge", state, 3'd0);
    START = 0; tick();
    START = 1; tick();
    chk("fresh_start_edge", state, 3'd1);
    START = 0; tick();

    // Randomized play against the model.
    for (int n = 0; n < 3000; n++) begin
      CLR       = ($urandom_range(0, 199) == 0);
      CE        = ($urandom_range(0, 7) != 0);
      OVERFLOW1 = ($urandom_range(0, 31) == 0);
      OVERFLOW2 = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 5) == 0) START  = ~START;
      if ($urandom_range(0, 5) == 0) PAUSE  = ~PAUSE;
      if ($urandom_range(0, 2) == 0) BTN_P1 = ~BTN_P1;
      if ($urandom_range(0, 2) == 0) BTN_P2 = ~BTN_P2;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/turn_controller.md
TURN_CONTROLLER -- requirements
Module: turn_controller

Interface
REQ-001 Parameter: MOVE_W, default 10, width of half-move counter.
REQ-002 Port: CLK  input  1  system clock; all state changes on rising edge.
REQ-003 Port: CLR  input  1  reset; synchronous, active-high.
REQ-004 Port: CE  input  1  global enable shared with prescalers/decoders.
REQ-005 Port: START  input  1  start / rematch button, level, pre-synchronized.
REQ-006 Port: PAUSE  input  1  pause/resume button, level, pre-synchronized.
REQ-007 Port: BTN_P1  input  1  player-1 move-done button, level, pre-synchronized.
REQ-008 Port: BTN_P2  input  1  player-2 move-done button, level, pre-synchronized.
REQ-009 Port: OVERFLOW1  input  1  player-1 timer expired.
REQ-010 Port: OVERFLOW2  input  1  player-2 timer expired.
REQ-011 Port: EN_P1  output  1  count enable (IMPULSE) for player-1 timer.
REQ-012 Port: EN_P2  output  1  count enable (IMPULSE) for player-2 timer.
REQ-013 Port: TMR_CLR  output  1  one-cycle clear pulse to both timers.
REQ-014 Port: FLAG_P1 / FLAG_P2  output  1 each  player lost on time, held.
REQ-015 Port: MOVE_CNT  output  MOVE_W  completed half-moves.
REQ-016 Port: STATE  output  3  current FSM state code.

Function
REQ-017 Each button SHALL be edge-detected: edge = input high now, registered copy low; one edge per press regardless of hold length.
REQ-018 FSM states SHALL be IDLE, RUN_P1, RUN_P2, PAUSED, TIMEOUT; all outputs registered, updated on the edge that first samples the button high.
REQ-019 IDLE: EN_P1=EN_P2=0; START edge -> RUN_P1; all other inputs ignored.
REQ-020 RUN_P1: EN_P1=1, EN_P2=0; BTN_P1 edge -> RUN_P2, MOVE_CNT+1; BTN_P2 ignored.
REQ-021 RUN_P2: EN_P2=1, EN_P1=0; BTN_P2 edge -> RUN_P1, MOVE_CNT+1; BTN_P1 ignored.
REQ-022 RUN_Px: PAUSE edge -> PAUSED, side x stored in a resume register.
REQ-023 RUN_Px: OVERFLOWx=1 -> TIMEOUT, FLAG_Px set; overflow of the idle side ignored.
REQ-024 Same-cycle priority in RUN_Px: OVERFLOWx > BTN_Px > PAUSE.
REQ-025 PAUSED: both EN=0; PAUSE edge -> stored RUN state; move buttons and START ignored.
REQ-026 TIMEOUT: both EN=0, flags held; START edge -> IDLE, TMR_CLR=1 for exactly one cycle, flags and MOVE_CNT cleared.
REQ-027 MOVE_CNT SHALL saturate at 2^MOVE_W-1, never wrap.
REQ-028 CE=0: FSM, counter and flags frozen, EN_P1/EN_P2 forced 0, TMR_CLR 0; edge registers keep sampling so no stale edge fires when CE returns.
REQ-029 Never EN_P1=EN_P2=1 in any cycle.

Reset
REQ-030 CLR=1 at a clock edge SHALL force IDLE, EN_P1=EN_P2=0, TMR_CLR=0, flags 0, MOVE_CNT 0, resume register RUN_P1, edge registers 0, any state, mid-game included.
REQ-031 A button held high through CLR release SHALL NOT generate an edge.

Structure
REQ-032 Shared package SHALL hold state codes (IDLE=0, RUN_P1=1, RUN_P2=2, PAUSED=3, TIMEOUT=4) and the MOVE_W default.
REQ-033 One sub-module, edge_detect (CLK, CLR, level in, pulse out), instanced four times.

Verification
REQ-034 CLR, START pulse -> RUN_P1, EN_P1=1 next cycle, STATE=1.
REQ-035 Alternate BTN_P1/BTN_P2 six presses, one held 20 cycles -> MOVE_CNT=6, one increment per press, no EN overlap.
REQ-036 RUN_P2, PAUSE, 10 cycles BTN_P2 toggling, PAUSE -> PAUSED with EN both 0, back to RUN_P2, MOVE_CNT unchanged.
REQ-037 RUN_P1, OVERFLOW1 and BTN_P1 same cycle -> TIMEOUT, FLAG_P1=1, MOVE_CNT unchanged; START -> IDLE, one-cycle TMR_CLR, flags 0.
REQ-038 MOVE_W=3, 9 moves -> MOVE_CNT stays 7.
REQ-039 CE=0 during RUN_P1 with BTN_P1 press and release -> no transition; CE=1 -> still RUN_P1, EN_P1=1; CLR mid-RUN_P2 -> IDLE, all outputs 0.
